run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter AUTORUN, default 0, selects the post-reset state: 0 = HALTED, 1 = RUN.
REQ-002 Parameter CNT_W, default 16, sets the instr_count width.
REQ-003 clk  in  1  single system clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run_req  in  1  level; request free-running execution.
REQ-006 halt_req  in  1  level; request a stop at the next instruction boundary.
REQ-007 step_req  in  1  level; request execution of exactly one instruction.
REQ-008 phase  in  1  CPU phase register; 0 = fetch, 1 = execute.
REQ-009 pc_addr  in  12  current CPU program counter.
REQ-010 bp_en  in  1  breakpoint enable.
REQ-011 bp_addr  in  12  breakpoint address.
REQ-012 cpu_en  out  1  clock enable to every CPU register, including PC, FETCH, FLAGS, PHASE and A.
REQ-013 state  out  2  current controller state.
REQ-014 bp_hit  out  1  sticky flag: the controller stopped on the breakpoint.
REQ-015 instr_count  out  CNT_W  count of completed instructions.

Function
REQ-016 Three states are defined: HALTED, RUN and STEP.
REQ-017 The instruction boundary is any cycle with phase==0.
REQ-018 An instruction completes on a cycle with cpu_en==1 and phase==1.
REQ-019 cpu_en is combinational from state, phase, pc_addr, bp_en, bp_addr, halt_pend, skip and halt_req.
REQ-020 In HALTED, cpu_en = 0.
REQ-021 In HALTED, halt_req has priority over step_req, and step_req has priority over run_req.
- halt_req: remain in HALTED.
- step_req: go to STEP and clear bp_hit.
- run_req: go to RUN, clear bp_hit and set the internal skip flag.
REQ-022 In RUN with phase==0, cpu_en = 0 and the next state is HALTED when any of these holds:
- halt_req==1;
- halt_pend==1;
- bp_en==1 and pc_addr==bp_addr and skip==0.
REQ-023 In RUN with phase==0, cpu_en = 1 and the state stays RUN when none of the REQ-022 conditions holds.
REQ-024 A stop caused by the breakpoint sets bp_hit; a stop caused by halt_req or halt_pend leaves bp_hit unchanged.
REQ-025 In RUN with phase==1, cpu_en = 1; if halt_req==1, halt_pend is set so the stop is taken at the next boundary.
REQ-026 The skip flag clears on the first cycle in RUN with cpu_en==1 and phase==0, so the instruction at a breakpoint can be resumed past.
REQ-027 In RUN, run_req and step_req are ignored.
REQ-028 In STEP, cpu_en = 1 for exactly two cycles (fetch, then execute), and the state returns to HALTED after the execute cycle.
REQ-029 In STEP, breakpoints, halt_req, run_req and step_req are ignored.
REQ-030 A held step_req executes one instruction per visit to HALTED: HALTED -> STEP -> HALTED -> STEP, ...
REQ-031 instr_count increments by 1 on each completion per REQ-018.
REQ-032 instr_count wraps from 2^CNT_W-1 to 0 with no flag.
REQ-033 Every halt lands on phase==0, so the CPU is never frozen mid-instruction.
REQ-034 halt_pend clears on entry to HALTED.

Reset
REQ-035 While reset is high:
- state = HALTED (AUTORUN=0) or RUN (AUTORUN=1);
- cpu_en = 0;
- bp_hit = 0, instr_count = 0, halt_pend = 0, skip = 0.
REQ-036 A reset asserted during RUN or STEP aborts the operation in the same edge, with no partial instruction counted.
REQ-037 The CPU shares the same reset, so phase==0 is guaranteed on the first cycle after reset.

Structure
REQ-038 A shared package holds:
- the state enum: HALTED=2'b00, RUN=2'b01, STEP=2'b10, with 2'b11 illegal and decoded as HALTED;
- the address-width constant ADDR_W = 12.
REQ-039 The instruction counter is one natural sub-module, instr_counter: CNT_W-wide, with enable and wrap.
REQ-040 The remaining logic is one FSM process plus combinational cpu_en decode.

Verification
REQ-041 Reset, AUTORUN=0, then run_req for one cycle:
- cpu_en high from the next cycle onward;
- after 10 instructions (20 cycles), instr_count = 10.
REQ-042 In RUN, halt_req pulses on a phase==1 cycle:
- cpu_en stays 1 for that cycle;
- next cycle: cpu_en = 0, state = HALTED, phase = 0.
REQ-043 bp_en=1, bp_addr=12'h005, run from PC 0:
- halts with pc_addr=12'h005, bp_hit=1, instr_count=5;
- then run_req: instruction 5 executes, with no re-halt at 12'h005.
REQ-044 From HALTED, step_req held 6 cycles:
- exactly 2 instructions complete (the pattern STEP, STEP, HALTED repeats);
- bp at the current PC does not block stepping.
REQ-045 CNT_W=4, run 17 instructions -> instr_count = 1 (wrap verified).
REQ-046 Reset asserted mid-STEP on the phase==0 cycle -> next cycle: state = HALTED, cpu_en = 0, instr_count = 0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding and address width for the run controller
package run_ctrl_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    HALTED = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10
  } state_t;

endpackage

// File: rtl/run_ctrl_instr_counter.sv
// rtl/run_ctrl_instr_counter.sv - completed-instruction counter, wraps silently at full scale
module instr_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run/halt/single-step controller gating the CPU clock enable
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int AUTORUN = 0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              phase,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  instr_count
);

  state_t state_r, state_nxt, cur;
  logic   bp_hit_nxt;
  logic   halt_pend, halt_pend_nxt;
  logic   skip, skip_nxt;
  logic   bp_match;
  logic   stop;

  // The unused encoding 2'b11 behaves exactly like HALTED.
  always_comb begin
    case (state_r)
      RUN:     cur = RUN;
      STEP:    cur = STEP;
      default: cur = HALTED;
    endcase
  end

  assign bp_match = bp_en && (pc_addr == bp_addr) && !skip;
  assign stop     = halt_req || halt_pend || bp_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= (AUTORUN != 0) ? RUN : HALTED;
      bp_hit    <= 1'b0;
      halt_pend <= 1'b0;
      skip      <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      bp_hit    <= bp_hit_nxt;
      halt_pend <= halt_pend_nxt;
      skip      <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt     = cur;
    bp_hit_nxt    = bp_hit;
    halt_pend_nxt = halt_pend;
    skip_nxt      = skip;
    case (cur)
      HALTED: begin
        halt_pend_nxt = 1'b0;
        if (halt_req) begin
          state_nxt = HALTED;
        end else if (step_req) begin
          state_nxt  = STEP;
          bp_hit_nxt = 1'b0;
        end else if (run_req) begin
          state_nxt  = RUN;
          bp_hit_nxt = 1'b0;
          skip_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (!phase) begin
          if (stop) begin
            state_nxt     = HALTED;
            halt_pend_nxt = 1'b0;
            // Only a pure breakpoint stop is reported as a hit.
            if (bp_match && !halt_req && !halt_pend) begin
              bp_hit_nxt = 1'b1;
            end
          end else begin
            skip_nxt = 1'b0;
          end
        end else if (halt_req) begin
          halt_pend_nxt = 1'b1;
        end
      end
      STEP: begin
        if (phase) begin
          state_nxt = HALTED;
        end
      end
      default: state_nxt = HALTED;
    endcase
  end

  // Mid-instruction halts are deferred, so RUN only drops the enable on a fetch cycle.
  always_comb begin
    cpu_en = 1'b0;
    if (!reset) begin
      case (cur)
        RUN:     cpu_en = phase || !stop;
        STEP:    cpu_en = 1'b1;
        default: cpu_en = 1'b0;
      endcase
    end
  end

  assign state = state_r;

  instr_counter #(
    .CNT_W (CNT_W)
  ) u_instr_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cpu_en && phase),
    .count (instr_count)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed vector bench for run_ctrl with a two-phase CPU model
module tb_run_ctrl;

  typedef struct {
    logic [3:0] in;   // {reset, run_req, halt_req, step_req}
    int         st;   // expected state, -1 = not checked
    logic       en;
    int         cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, run_req, halt_req, step_req;
  logic        phase;
  logic [11:0] pc;
  logic        bp_en;
  logic [11:0] bp_addr;

  logic        cpu_en, bp_hit;
  logic [1:0]  state;
  logic [15:0] instr_count;

  logic        cpu_en4, bp_hit4;
  logic [1:0]  state4;
  logic [3:0]  instr_count4;

  logic        cpu_en_ar, bp_hit_ar;
  logic [1:0]  state_ar;
  logic [15:0] instr_count_ar;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[23];

  always #5 clk = ~clk;

  run_ctrl dut (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .phase(phase), .pc_addr(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .instr_count(instr_count)
  );

  run_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .phase(phase), .pc_addr(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .cpu_en(cpu_en4), .state(state4), .bp_hit(bp_hit4), .instr_count(instr_count4)
  );

  run_ctrl #(.AUTORUN(1)) dut_ar (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .phase(phase), .pc_addr(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .cpu_en(cpu_en_ar), .state(state_ar), .bp_hit(bp_hit_ar), .instr_count(instr_count_ar)
  );

  // CPU model: fetch/execute alternate while enabled, PC advances after execute.
  always @(posedge clk) begin
    if (reset) begin
      phase <= 1'b0;
      pc    <= '0;
    end else if (cpu_en) begin
      phase <= ~phase;
      if (phase) pc <= pc + 12'd1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] in, input int st, input logic en, input int cnt);
    vec_t v;
    v.in = in; v.st = st; v.en = en; v.cnt = cnt;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    bp_en = 1'b0; bp_addr = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_to_breakpoint();
    do_reset();
    bp_en = 1'b1; bp_addr = 12'h005;
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    for (int k = 0; k < 40 && state != 2'd0; k++) @(negedge clk);
    #1;
    check("bp_halt_state", int'(state), 0);
    check("bp_halt_pc", int'(pc), 5);
    check("bp_halt_hit", int'(bp_hit), 1);
    check("bp_halt_count", int'(instr_count), 5);
    check("bp_halt_phase", int'(phase), 0);
  endtask

  initial begin
    tbl[0]  = mk(4'b1000,  0, 1'b0, 0);
    tbl[1]  = mk(4'b0001,  0, 1'b0, 0);
    tbl[2]  = mk(4'b0001,  2, 1'b1, 0);
    tbl[3]  = mk(4'b0011,  2, 1'b1, 0);
    tbl[4]  = mk(4'b0011,  0, 1'b0, 1);
    tbl[5]  = mk(4'b0101,  0, 1'b0, 1);
    tbl[6]  = mk(4'b0100,  2, 1'b1, 1);
    tbl[7]  = mk(4'b0000,  2, 1'b1, 1);
    tbl[8]  = mk(4'b0100,  0, 1'b0, 2);
    tbl[9]  = mk(4'b0001,  1, 1'b1, 2);
    tbl[10] = mk(4'b0000,  1, 1'b1, 2);
    tbl[11] = mk(4'b0010,  1, 1'b0, 3);
    tbl[12] = mk(4'b0000,  0, 1'b0, 3);
    tbl[13] = mk(4'b0100,  0, 1'b0, 3);
    tbl[14] = mk(4'b0000,  1, 1'b1, 3);
    tbl[15] = mk(4'b0010,  1, 1'b1, 3);
    tbl[16] = mk(4'b0000, -1, 1'b0, 4);
    tbl[17] = mk(4'b0000,  0, 1'b0, 4);
    tbl[18] = mk(4'b0100,  0, 1'b0, 4);
    tbl[19] = mk(4'b0000,  1, 1'b1, 4);
    tbl[20] = mk(4'b0000,  1, 1'b1, 4);
    tbl[21] = mk(4'b1000,  1, 1'b0, 5);
    tbl[22] = mk(4'b0000,  0, 1'b0, 0);

    do_reset();
    reset = 1'b1;
    #1;
    check("autorun_reset_state", int'(state_ar), 1);
    check("autorun_reset_en", int'(cpu_en_ar), 0);
    check("autorun_reset_count", int'(instr_count_ar), 0);
    check("autorun_reset_bp", int'(bp_hit_ar), 0);

    for (int i = 0; i < 23; i++) begin
      {reset, run_req, halt_req, step_req} = tbl[i].in;
      #1;
      if (tbl[i].st >= 0) check($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
      check($sformatf("vec%0d_cpu_en", i), int'(cpu_en), int'(tbl[i].en));
      check($sformatf("vec%0d_count", i), int'(instr_count), tbl[i].cnt);
      check($sformatf("vec%0d_bp_hit", i), int'(bp_hit), 0);
      if (i == 16) check("halt_pend_phase", int'(phase), 0);
      @(negedge clk);
    end

    // Free run of ten instructions after a one-cycle run request.
    begin
      int low = 0;
      do_reset();
      run_req = 1'b1;
      @(negedge clk);
      run_req = 1'b0;
      for (int k = 0; k < 20; k++) begin
        #1;
        if (!cpu_en) low++;
        @(negedge clk);
      end
      #1;
      check("run10_en_low_cycles", low, 0);
      check("run10_count", int'(instr_count), 10);
      check("run10_pc", int'(pc), 10);
    end

    // Resume past the breakpoint.
    run_to_breakpoint();
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    for (int k = 0; k < 10 && pc != 12'd6; k++) @(negedge clk);
    #1;
    check("resume_pc", int'(pc), 6);
    check("resume_state", int'(state), 1);
    check("resume_count", int'(instr_count), 6);
    check("resume_bp_clear", int'(bp_hit), 0);

    // Held step from a breakpoint halt: two instructions in six cycles.
    run_to_breakpoint();
    step_req = 1'b1;
    repeat (6) @(negedge clk);
    step_req = 1'b0;
    #1;
    check("step6_count", int'(instr_count), 7);
    check("step6_pc", int'(pc), 7);
    check("step6_state", int'(state), 0);
    check("step6_bp_clear", int'(bp_hit), 0);

    // 4-bit counter wraps after 16.
    do_reset();
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    for (int k = 0; k < 60 && instr_count != 16'd17; k++) @(negedge clk);
    halt_req = 1'b1;
    #1;
    check("wrap_en_match", int'(cpu_en4), int'(cpu_en));
    @(negedge clk);
    halt_req = 1'b0;
    #1;
    check("wrap_count16", int'(instr_count), 17);
    check("wrap_count4", int'(instr_count4), 1);
    check("wrap_state4", int'(state4), 0);
    check("wrap_bp4", int'(bp_hit4), 0);

    // Reset on the fetch cycle of a step.
    do_reset();
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("prestep_count", int'(instr_count), 1);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    #1;
    check("midstep_state", int'(state), 2);
    check("midstep_phase", int'(phase), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_state", int'(state), 0);
    check("abort_en", int'(cpu_en), 0);
    check("abort_count", int'(instr_count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
